dffram_arbiter: RTL and testbench
=================================

# dffram_arbiter

Two-port round-robin arbiter and sequencer in front of a single `DFFRAM` instance (32-bit words, byte write enables, 1-cycle registered read). It shares the RAM between two requesters, for example a Wishbone slave and a BIST engine. It runs one RAM access per cycle, fully pipelined, and returns a registered response to the owning port. After reset it can optionally zero-fill the whole RAM before serving requests.

## Interface
- `COLS`, default 1: RAM depth is 256*COLS words. `A_WIDTH` = 8+$clog2(COLS).
- `CLEAR_ON_RESET`, default 1: when 1, zero-fill the RAM after reset before serving requests.
- Clock and reset: one clock, `CLK`. Reset is `RSTn`, asynchronous and active-low.
- `CLK`  in  1  clock.
- `RSTn`  in  1  asynchronous active-low reset.
- `p0_req` / `p1_req`  in  1  request valid; held until granted.
- `p0_we` / `p1_we`  in  4  byte write enables; 0 means read.
- `p0_a` / `p1_a`  in  A_WIDTH  word address.
- `p0_di` / `p1_di`  in  32  write data.
- `p0_gnt` / `p1_gnt`  out  1  combinational; request accepted this cycle.
- `p0_ack` / `p1_ack`  out  1  one-cycle response pulse.
- `p0_do` / `p1_do`  out  32  read data, valid while ack is high, held afterwards.
- `ready`  out  1  registered; high once the clear pass is done.
- `ram_EN`  out  1  RAM enable.
- `ram_WE`  out  4  RAM byte write enables.
- `ram_A`  out  A_WIDTH  RAM address.
- `ram_Di`  out  32  RAM write data.
- `ram_Do`  in  32  RAM read data.

## Operation
- FSM states: CLEAR and RUN. Reset state:
  - CLEAR if `CLEAR_ON_RESET`=1;
  - RUN otherwise.
- CLEAR state:
  - Address counter runs 0 .. 256*COLS-1, one word per cycle.
  - RAM drive: `ram_EN`=1, `ram_WE`=4'hF, `ram_Di`=0.
  - Both `gnt` outputs are 0.
  - After the last address, go to RUN. No acks are generated for clear writes.
- RUN state, grant rules:
  - One request pending: it is granted.
  - Both pending: grant the port that was not granted most recently.
  - The last-grant pointer resets to "p1", so p0 wins the first tie. It updates only on a grant.
- RUN state, RAM drive:
  - Winner's `we`/`a`/`di` go to the RAM with `ram_EN`=1.
  - No grant: `ram_EN`=0, `ram_WE`=0. `ram_A` and `ram_Di` are don't-care but must not be X.
- Response pipeline:
  - Stage 1 registers valid and owner at the accept edge.
  - Stage 2 captures `ram_Do` into the owner's `do` register and sets the owner's `ack`.
  - Writes also ack. On a write, `do` returns the old word, because the RAM reads before it writes.
  - A non-owner's `do` is unchanged.
- `ready`: 1 in RUN, 0 in CLEAR.

## Timing
- Accept cycle T: `req`&&`gnt` high. RAM samples at the end of T.
- `ram_Do` is valid in T+1. The owner's `ack`=1 and `do` is valid in T+2.
- Fixed latency: 2 cycles from accept to ack.
- Throughput: 1 access per cycle. Back-to-back accepts give back-to-back acks in the same order.
- Reset values: `gnt`=0, `ack`=0, `do`=0, `ram_EN`=0, `ram_WE`=0, `ready`=0, pipeline valids 0.
- `CLEAR_ON_RESET`=1: the first clear write is in the first cycle after `RSTn` rises. `ready` rises at the edge ending the last clear write (after 256*COLS cycles). First grant is possible in the next cycle.
- `CLEAR_ON_RESET`=0: `ready` rises at the first edge after `RSTn` rises. Grants are allowed from that first cycle.
- `RSTn` asserted mid-operation: in-flight acks are discarded, pointer and counter reset, and the clear pass restarts from address 0.
- Wrap-around: the clear counter stops at the last address and does not wrap.
- The request port must hold `we`/`a`/`di` stable while `req` is high and `gnt` is low.

## Test plan
- Clear pass, COLS=1: `RSTn` released → `ready` rises after exactly 256 cycles. Reading addresses 0, 128 and 255 each gives `do`=0 with `ack` 2 cycles after accept.
- Write then read: p0 writes 32'hDEADBEEF to address 5 (`we`=F), then reads address 5. Write-ack `do` = old value 0; read-ack `do`=32'hDEADBEEF.
- Byte enables: write 32'h11223344 to address 7, then `we`=4'b0100 with `di`=32'hAAAAAAAA, then read address 7 → 32'h11AA3344.
- Contention: both ports request continuously for 8 cycles. Grants alternate p0,p1,p0,… with p0 first. Each port gets 4 acks in order. `ram_EN` is high in all 8 cycles.
- Single requester streaming: p1 reads addresses 0..9 with `req` held high. `p1_gnt` is high every cycle and acks arrive on 10 consecutive cycles.
- Reset mid-operation: assert `RSTn` low during clear at address 100 and again with 2 reads in flight. All acks drop to 0 immediately, `ready`=0, and the clear restarts at address 0.

Source files
------------

// File: rtl/dffram_arbiter.sv
// Two-port round-robin arbiter and response sequencer in front of a single DFFRAM.
// Optionally zero-fills the whole RAM after reset before any request is served.
module dffram_arbiter #(
  parameter int COLS           = 1,
  parameter int CLEAR_ON_RESET = 1,
  localparam int A_WIDTH       = 8 + $clog2(COLS)
) (
  input  logic               CLK,
  input  logic               RSTn,
  input  logic               p0_req,
  input  logic [3:0]         p0_we,
  input  logic [A_WIDTH-1:0] p0_a,
  input  logic [31:0]        p0_di,
  output logic               p0_gnt,
  output logic               p0_ack,
  output logic [31:0]        p0_do,
  input  logic               p1_req,
  input  logic [3:0]         p1_we,
  input  logic [A_WIDTH-1:0] p1_a,
  input  logic [31:0]        p1_di,
  output logic               p1_gnt,
  output logic               p1_ack,
  output logic [31:0]        p1_do,
  output logic               ready,
  output logic               ram_EN,
  output logic [3:0]         ram_WE,
  output logic [A_WIDTH-1:0] ram_A,
  output logic [31:0]        ram_Di,
  input  logic [31:0]        ram_Do
);

  typedef enum logic {ST_CLEAR = 1'b0, ST_RUN = 1'b1} state_t;

  localparam state_t             RST_STATE = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_RUN;
  localparam logic [A_WIDTH-1:0] LAST_ADDR = A_WIDTH'(256 * COLS - 1);

  state_t             state_r;
  logic [A_WIDTH-1:0] clr_addr_r;
  logic               ready_r;
  logic               last_p1_r;
  logic               s1_vld_r;
  logic               s1_own_r;
  logic               p0_ack_r;
  logic               p1_ack_r;
  logic [31:0]        p0_do_r;
  logic [31:0]        p1_do_r;
  logic               clear_s;
  logic               run_s;
  logic               gnt0_s;
  logic               gnt1_s;

  // Clear sequencer: walk the address range once, then hand the RAM to the requesters
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_r    <= RST_STATE;
      clr_addr_r <= {A_WIDTH{1'b0}};
      ready_r    <= 1'b0;
    end else begin
      case (state_r)
        ST_CLEAR: begin
          if (clr_addr_r == LAST_ADDR) begin
            state_r <= ST_RUN;
            ready_r <= 1'b1;
          end else begin
            clr_addr_r <= clr_addr_r + {{(A_WIDTH-1){1'b0}}, 1'b1};
          end
        end
        ST_RUN: ready_r <= 1'b1;
        default: begin
          state_r <= RST_STATE;
          ready_r <= 1'b0;
        end
      endcase
    end
  end

  // Grant decision; RSTn gating keeps the RAM idle and grants low while reset is held
  always_comb begin
    clear_s = RSTn && (state_r == ST_CLEAR);
    run_s   = RSTn && (state_r == ST_RUN);
    gnt0_s  = run_s && p0_req && (!p1_req || last_p1_r);
    gnt1_s  = run_s && p1_req && !gnt0_s;
  end

  // RAM drive: clear writes, the winning port, or a quiet bus with known values
  always_comb begin
    ram_EN = 1'b0;
    ram_WE = 4'h0;
    ram_A  = {A_WIDTH{1'b0}};
    ram_Di = 32'h0000_0000;
    if (clear_s) begin
      ram_EN = 1'b1;
      ram_WE = 4'hF;
      ram_A  = clr_addr_r;
    end else if (gnt0_s) begin
      ram_EN = 1'b1;
      ram_WE = p0_we;
      ram_A  = p0_a;
      ram_Di = p0_di;
    end else if (gnt1_s) begin
      ram_EN = 1'b1;
      ram_WE = p1_we;
      ram_A  = p1_a;
      ram_Di = p1_di;
    end else begin
      ram_EN = 1'b0;
    end
  end

  // Round-robin pointer, moves only when someone is granted
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      last_p1_r <= 1'b1;
    end else if (gnt0_s) begin
      last_p1_r <= 1'b0;
    end else if (gnt1_s) begin
      last_p1_r <= 1'b1;
    end else begin
      last_p1_r <= last_p1_r;
    end
  end

  // Response pipeline: stage 1 tracks the owner while the RAM reads, stage 2 returns data
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      s1_vld_r <= 1'b0;
      s1_own_r <= 1'b0;
      p0_ack_r <= 1'b0;
      p1_ack_r <= 1'b0;
      p0_do_r  <= 32'h0000_0000;
      p1_do_r  <= 32'h0000_0000;
    end else begin
      s1_vld_r <= gnt0_s || gnt1_s;
      s1_own_r <= gnt1_s;
      p0_ack_r <= s1_vld_r && !s1_own_r;
      p1_ack_r <= s1_vld_r && s1_own_r;
      if (s1_vld_r && !s1_own_r) begin
        p0_do_r <= ram_Do;
      end
      if (s1_vld_r && s1_own_r) begin
        p1_do_r <= ram_Do;
      end
    end
  end

  assign p0_gnt = gnt0_s;
  assign p1_gnt = gnt1_s;
  assign p0_ack = p0_ack_r;
  assign p1_ack = p1_ack_r;
  assign p0_do  = p0_do_r;
  assign p1_do  = p1_do_r;
  assign ready  = ready_r;

endmodule

// File: tb/tb_dffram_arbiter.sv
// Randomized scoreboard bench for dffram_arbiter with a behavioural DFFRAM and reference model.
module tb_dffram_arbiter;

  typedef struct {
    logic [31:0] d;
    int          due;
  } exp_t;

  logic        CLK = 1'b0;
  logic        RSTn = 1'b0;
  logic        req_v [2];
  logic [3:0]  we_v [2];
  logic [7:0]  a_v [2];
  logic [31:0] di_v [2];
  logic        p0_gnt, p1_gnt, p0_ack, p1_ack, ready;
  logic [31:0] p0_do, p1_do;
  logic        ram_EN;
  logic [3:0]  ram_WE;
  logic [7:0]  ram_A;
  logic [31:0] ram_Di;
  logic [31:0] ram_Do;
  logic [31:0] ram_mem [256];

  logic [31:0] mem_m [256];
  logic [31:0] last_do [2];
  exp_t        q0 [$];
  exp_t        q1 [$];
  int          last_m;
  bit          run_m;
  int          clr_idx;
  int          cyc = 0;
  int          checks = 0;
  int          failures = 0;

  always #5 CLK = ~CLK;

  dffram_arbiter #(.COLS(1), .CLEAR_ON_RESET(1)) dut (
    .CLK(CLK), .RSTn(RSTn),
    .p0_req(req_v[0]), .p0_we(we_v[0]), .p0_a(a_v[0]), .p0_di(di_v[0]),
    .p0_gnt(p0_gnt), .p0_ack(p0_ack), .p0_do(p0_do),
    .p1_req(req_v[1]), .p1_we(we_v[1]), .p1_a(a_v[1]), .p1_di(di_v[1]),
    .p1_gnt(p1_gnt), .p1_ack(p1_ack), .p1_do(p1_do),
    .ready(ready), .ram_EN(ram_EN), .ram_WE(ram_WE), .ram_A(ram_A),
    .ram_Di(ram_Di), .ram_Do(ram_Do)
  );

  // Behavioural DFFRAM: registered read of the old word, byte-masked write
  initial begin
    for (int i = 0; i < 256; i++) ram_mem[i] = $urandom();
  end
  always @(posedge CLK) begin
    if (ram_EN) begin
      ram_Do <= ram_mem[ram_A];
      for (int b = 0; b < 4; b++)
        if (ram_WE[b]) ram_mem[ram_A][8*b +: 8] <= ram_Di[8*b +: 8];
    end
  end

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h (cycle %0d)", nm, got, exp, cyc);
    end
  endtask

  // Scoreboard monitor for one port: data, latency, missing acks and hold behaviour
  task automatic mon_port(input int p, input logic ack, input logic [31:0] dout);
    exp_t e;
    int   n;
    n = (p == 0) ? q0.size() : q1.size();
    if (ack) begin
      if (n == 0) begin
        checks++;
        failures++;
        $display("FAIL p%0d_ack_unexpected got ack=1 exp ack=0 (cycle %0d)", p, cyc);
      end else begin
        if (p == 0) e = q0.pop_front(); else e = q1.pop_front();
        chk($sformatf("p%0d_do", p), dout, e.d);
        chk($sformatf("p%0d_ack_cycle", p), 32'(cyc), 32'(e.due));
        last_do[p] = e.d;
      end
    end else begin
      chk($sformatf("p%0d_do_hold", p), dout, last_do[p]);
      if (n != 0) begin
        if (p == 0) e = q0[0]; else e = q1[0];
        if (e.due <= cyc) begin
          checks++;
          failures++;
          $display("FAIL p%0d_ack_missing got ack=0 exp ack=1 (cycle %0d)", p, cyc);
          if (p == 0) void'(q0.pop_front()); else void'(q1.pop_front());
        end
      end
    end
  endtask

  always @(negedge CLK) begin
    if (RSTn) begin
      mon_port(0, p0_ack, p0_do);
      mon_port(1, p1_ack, p1_do);
    end
  end

  task automatic issue(input int p, input logic [3:0] we, input logic [7:0] a, input logic [31:0] di);
    req_v[p] = 1'b1;
    we_v[p]  = we;
    a_v[p]   = a;
    di_v[p]  = di;
  endtask

  // One clock: predict grant from the round-robin rule, check RAM drive, record expected response
  task automatic tick();
    bit   g0, g1;
    int   w;
    exp_t e;
    @(negedge CLK);
    g0 = run_m && req_v[0] && (!req_v[1] || last_m == 1);
    g1 = run_m && req_v[1] && !g0;
    w  = g1 ? 1 : 0;
    chk("p0_gnt", 32'(p0_gnt), 32'(g0));
    chk("p1_gnt", 32'(p1_gnt), 32'(g1));
    chk("ready", 32'(ready), 32'(run_m));
    if (!run_m) begin
      chk("clr_en", 32'(ram_EN), 32'd1);
      chk("clr_we", 32'(ram_WE), 32'hF);
      chk("clr_addr", 32'(ram_A), 32'(clr_idx));
      chk("clr_di", ram_Di, 32'd0);
      clr_idx++;
    end else begin
      chk("ram_en", 32'(ram_EN), 32'(g0 | g1));
      chk("ram_known", 32'($isunknown({ram_A, ram_Di, ram_WE})), 32'd0);
    end
    if (g0 || g1) begin
      chk("ram_a", 32'(ram_A), 32'(a_v[w]));
      chk("ram_we", 32'(ram_WE), 32'(we_v[w]));
      if (we_v[w] != 4'h0) chk("ram_di", ram_Di, di_v[w]);
      e.d   = mem_m[a_v[w]];
      e.due = cyc + 2;
      if (w == 0) q0.push_back(e); else q1.push_back(e);
      for (int b = 0; b < 4; b++)
        if (we_v[w][b]) mem_m[a_v[w]][8*b +: 8] = di_v[w][8*b +: 8];
      last_m = w;
    end
    @(posedge CLK);
    #1;
    if (g0 || g1) req_v[w] = 1'b0;
    if (!run_m && clr_idx == 256) run_m = 1'b1;
  endtask

  task automatic do_reset();
    RSTn     = 1'b0;
    req_v[0] = 1'b1;
    req_v[1] = 1'b1;
    #1;
    chk("rst_p0_ack", 32'(p0_ack), 32'd0);
    chk("rst_p1_ack", 32'(p1_ack), 32'd0);
    chk("rst_p0_gnt", 32'(p0_gnt), 32'd0);
    chk("rst_p1_gnt", 32'(p1_gnt), 32'd0);
    chk("rst_ready", 32'(ready), 32'd0);
    chk("rst_ram_en", 32'(ram_EN), 32'd0);
    chk("rst_ram_we", 32'(ram_WE), 32'd0);
    chk("rst_p0_do", p0_do, 32'd0);
    chk("rst_p1_do", p1_do, 32'd0);
    req_v[0] = 1'b0;
    req_v[1] = 1'b0;
    q0.delete();
    q1.delete();
    last_do[0] = 32'd0;
    last_do[1] = 32'd0;
    run_m   = 1'b0;
    clr_idx = 0;
    last_m  = 1;
    for (int i = 0; i < 256; i++) mem_m[i] = 32'd0;
    @(posedge CLK);
    @(posedge CLK);
    #2;
    RSTn = 1'b1;
  endtask

  task automatic wait_clear();
    int n;
    n = 0;
    while (!run_m && n < 300) begin
      tick();
      n++;
    end
    chk("clear_done", 32'(run_m), 32'd1);
  endtask

  task automatic run_until_idle();
    int n;
    n = 0;
    while ((req_v[0] || req_v[1]) && n < 50) begin
      tick();
      n++;
    end
    chk("req_served", 32'(req_v[0] | req_v[1]), 32'd0);
  endtask

  task automatic drain();
    repeat (4) tick();
  endtask

  initial begin
    for (int p = 0; p < 2; p++) begin
      req_v[p] = 1'b0;
      we_v[p]  = 4'h0;
      a_v[p]   = 8'h00;
      di_v[p]  = 32'd0;
    end
    do_reset();
    repeat (100) tick();
    chk("clr_idx_100", 32'(clr_idx), 32'd100);
    do_reset();
    wait_clear();

    foreach (a_v[i]) ;
    issue(0, 4'h0, 8'd0, 32'd0);   run_until_idle();
    issue(0, 4'h0, 8'd128, 32'd0); run_until_idle();
    issue(0, 4'h0, 8'd255, 32'd0); run_until_idle();
    drain();

    issue(0, 4'hF, 8'd5, 32'hDEADBEEF); run_until_idle();
    issue(0, 4'h0, 8'd5, 32'd0);        run_until_idle();
    drain();
    chk("rd_deadbeef", p0_do, 32'hDEADBEEF);

    issue(0, 4'hF, 8'd7, 32'h11223344); run_until_idle();
    issue(0, 4'b0100, 8'd7, 32'hAAAAAAAA); run_until_idle();
    issue(0, 4'h0, 8'd7, 32'd0);        run_until_idle();
    drain();
    chk("rd_byte_en", p0_do, 32'h11AA3344);

    for (int i = 0; i < 10; i++) begin
      issue(1, 4'h0, 8'(i), 32'd0);
      tick();
    end
    drain();

    issue(0, 4'h0, 8'd3, 32'd0); tick();
    issue(0, 4'h0, 8'd4, 32'd0); tick();
    do_reset();
    wait_clear();

    for (int i = 0; i < 8; i++) begin
      for (int p = 0; p < 2; p++)
        if (!req_v[p]) issue(p, 4'h0, 8'($urandom_range(0, 255)), 32'd0);
      tick();
    end
    run_until_idle();
    drain();

    for (int i = 0; i < 1500; i++) begin
      for (int p = 0; p < 2; p++)
        if (!req_v[p] && $urandom_range(0, 3) != 0)
          issue(p, ($urandom_range(0, 1) != 0) ? 4'h0 : 4'($urandom_range(1, 15)),
                8'($urandom_range(0, 31)), $urandom());
      tick();
    end
    run_until_idle();
    drain();
    chk("q0_empty", 32'(q0.size()), 32'd0);
    chk("q1_empty", 32'(q1.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
